geofence_n: RTL and testbench

GEOFENCE_N -- requirements
Module: geofence_n

---
 rtl/geofence_pkg.sv | 36 +++
 rtl/geofence_cross_sign.sv | 57 +++++
 rtl/geofence_n.sv | 183 ++++++++++++++++++
 tb/tb_geofence_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/geofence_pkg.sv
// ============================================================================
// Module      : geofence_pkg
// Description : Shared FSM state encoding and arithmetic width helpers for the
//               convex-fence point-in-polygon block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package geofence_pkg;

  // Transaction phases: gather samples, order vertices CCW, test target, report
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Signed coordinate difference: one extra bit over the unsigned coordinate
  function automatic int diff_w(input int cw);
    return cw + 1;
  endfunction

  // Product of two differences, sized so no product can overflow
  function automatic int prod_w(input int cw);
    return 2 * cw + 2;
  endfunction

  // Difference of two products (the 2-D cross product)
  function automatic int cross_w(input int cw);
    return 2 * cw + 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/geofence_cross_sign.sv
// ============================================================================
// Module      : cross_sign
// Description : Sign of the 2-D cross product (A-O) x (B-O) for unsigned
//               CW-bit coordinates; reports negative and exactly-zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cross_sign
  import geofence_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic [CW-1:0] a_x_i,
  input  logic [CW-1:0] a_y_i,
  input  logic [CW-1:0] b_x_i,
  input  logic [CW-1:0] b_y_i,
  input  logic [CW-1:0] o_x_i,
  input  logic [CW-1:0] o_y_i,
  output logic          neg_o,
  output logic          zero_o
);

  localparam int DW = diff_w(CW);
  localparam int PW = prod_w(CW);
  localparam int XW = cross_w(CW);

  logic signed [DW-1:0] w_dax, w_day, w_dbx, w_dby;
  logic signed [PW-1:0] w_dax_e, w_day_e, w_dbx_e, w_dby_e;
  logic signed [PW-1:0] w_p1, w_p2;
  logic signed [XW-1:0] w_cross;

  // Differences relative to the origin; the leading zero makes each operand
  // non-negative before subtraction so the result range is exact.
  assign w_dax = $signed({1'b0, a_x_i}) - $signed({1'b0, o_x_i});
  assign w_day = $signed({1'b0, a_y_i}) - $signed({1'b0, o_y_i});
  assign w_dbx = $signed({1'b0, b_x_i}) - $signed({1'b0, o_x_i});
  assign w_dby = $signed({1'b0, b_y_i}) - $signed({1'b0, o_y_i});

  // Sign-extend to product width so the multiply is carried out at full size
  assign w_dax_e = {{(PW-DW){w_dax[DW-1]}}, w_dax};
  assign w_day_e = {{(PW-DW){w_day[DW-1]}}, w_day};
  assign w_dbx_e = {{(PW-DW){w_dbx[DW-1]}}, w_dbx};
  assign w_dby_e = {{(PW-DW){w_dby[DW-1]}}, w_dby};

  assign w_p1 = w_dax_e * w_dby_e;
  assign w_p2 = w_day_e * w_dbx_e;

  // One more bit for the final subtraction of two full-range products
  assign w_cross = {w_p1[PW-1], w_p1} - {w_p2[PW-1], w_p2};

  assign neg_o  = w_cross[XW-1];
  assign zero_o = (w_cross == '0);

endmodule

`default_nettype wire

// File: rtl/geofence_n.sv
// ============================================================================
// Module      : geofence_n
// Description : Accepts a target point and N convex-fence vertices, sorts the
//               vertices counterclockwise around V[0], then tests whether the
//               target lies inside or on the fence. One cross-product unit is
//               time-shared between the sort and the test.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module geofence_n
  import geofence_pkg::*;
#(
  parameter int N  = 6,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  output logic          ready,
  output logic          valid,
  output logic          is_inside,
  output logic          on_edge
);

  localparam int             IW     = $clog2(N);
  localparam logic [IW-1:0]  LAST   = IW'(N - 1);
  localparam logic [IW-1:0]  PENULT = IW'(N - 2);

  state_e        state_q;
  logic          have_t_q;
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] k_q;
  logic [IW-1:0] j_q;
  logic [IW-1:0] i_q;
  logic          neg_q;
  logic          zero_q;
  logic          valid_q;
  logic          inside_q;
  logic          edge_q;

  logic [CW-1:0] tx_q;
  logic [CW-1:0] ty_q;
  logic [CW-1:0] vx_q [N];
  logic [CW-1:0] vy_q [N];

  logic [IW-1:0] w_ip1;
  logic [CW-1:0] w_ax, w_ay, w_bx, w_by, w_ox, w_oy;
  logic          w_neg;
  logic          w_zero;

  // Successor vertex index for the edge under test, closing the polygon
  assign w_ip1 = (i_q == LAST) ? '0 : (i_q + IW'(1));

  // Operand select: SORT compares V[k] and V[j] around the anchor V[0];
  // CHECK tests T against edge V[i] -> V[i+1].
  always_comb begin
    w_ax = vx_q[k_q];
    w_ay = vy_q[k_q];
    w_bx = vx_q[j_q];
    w_by = vy_q[j_q];
    w_ox = vx_q[0];
    w_oy = vy_q[0];
    if (state_q == CHECK) begin
      w_ax = vx_q[w_ip1];
      w_ay = vy_q[w_ip1];
      w_bx = tx_q;
      w_by = ty_q;
      w_ox = vx_q[i_q];
      w_oy = vy_q[i_q];
    end
  end

  cross_sign #(
    .CW (CW)
  ) u_cross (
    .a_x_i  (w_ax),
    .a_y_i  (w_ay),
    .b_x_i  (w_bx),
    .b_y_i  (w_by),
    .o_x_i  (w_ox),
    .o_y_i  (w_oy),
    .neg_o  (w_neg),
    .zero_o (w_zero)
  );

  // Control FSM: sample counting, sort pair walk, edge walk and result flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      have_t_q <= 1'b0;
      cnt_q    <= '0;
      k_q      <= '0;
      j_q      <= '0;
      i_q      <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      inside_q <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            if (!have_t_q) begin
              have_t_q <= 1'b1;
            end else if (cnt_q == LAST) begin
              state_q  <= SORT;
              have_t_q <= 1'b0;
              cnt_q    <= '0;
              k_q      <= IW'(1);
              j_q      <= IW'(2);
              neg_q    <= 1'b0;
              zero_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + IW'(1);
            end
          end
        end
        SORT: begin
          if (j_q == LAST) begin
            if (k_q == PENULT) begin
              state_q <= CHECK;
              i_q     <= '0;
            end else begin
              k_q <= k_q + IW'(1);
              j_q <= k_q + IW'(2);
            end
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        CHECK: begin
          neg_q  <= neg_q | w_neg;
          zero_q <= zero_q | w_zero;
          if (i_q == LAST) begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            inside_q <= !(neg_q | w_neg);
            edge_q   <= !(neg_q | w_neg) && (zero_q | w_zero);
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        DONE: begin
          state_q <= LOAD;
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  // Sample capture and in-place vertex swap; storage needs no reset value
  always_ff @(posedge clk) begin
    if ((state_q == LOAD) && in_valid) begin
      if (!have_t_q) begin
        tx_q <= X;
        ty_q <= Y;
      end else begin
        vx_q[cnt_q] <= X;
        vy_q[cnt_q] <= Y;
      end
    end else if ((state_q == SORT) && w_neg) begin
      vx_q[k_q] <= vx_q[j_q];
      vy_q[k_q] <= vy_q[j_q];
      vx_q[j_q] <= vx_q[k_q];
      vy_q[j_q] <= vy_q[k_q];
    end
  end

  assign ready     = (state_q == LOAD);
  assign valid     = valid_q;
  assign is_inside = inside_q;
  assign on_edge   = edge_q;

endmodule

`default_nettype wire

// File: tb/tb_geofence_n.sv
// ============================================================================
// Module      : tb_geofence_n
// Description : Directed scoreboard bench for geofence_n (N=6, CW=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_geofence_n;

  localparam int N  = 6;
  localparam int CW = 10;
  localparam int LAT = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [CW-1:0] X;
  logic [CW-1:0] Y;
  logic          ready;
  logic          valid;
  logic          is_inside;
  logic          on_edge;

  geofence_n #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .ready     (ready),
    .valid     (valid),
    .is_inside (is_inside),
    .on_edge   (on_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ins;
    logic edg;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Vertex sets: 0 = small hexagon, 1 = full-range hexagon
  int vxs [2][6] = '{'{8, 0, 4, 0, 8, 4}, '{767, 0, 256, 1023, 256, 767}};
  int vys [2][6] = '{'{8, 2, 0, 8, 2, 10}, '{1023, 512, 0, 512, 1023, 0}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted sample; an optional idle cycle before it carries junk data
  task automatic put(input int x, input int y, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      X = 10'd1023;
      Y = 10'd1023;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    X = CW'(x);
    Y = CW'(y);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_txn(input int tx, input int ty, input int set, input bit gap, input bit rev);
    put(tx, ty, 1'b0);
    for (int v = 0; v < N; v++) begin
      int idx;
      idx = rev ? (N - 1 - v) : v;
      put(vxs[set][idx], vys[set][idx], gap);
    end
  endtask

  task automatic run_txn(input string tag, input int tx, input int ty, input int set,
                         input logic ei, input logic ee, input bit gap, input bit hold);
    exp_t e;
    int   cyc;
    bit   got;
    bit   busy_ok;
    e.ins = ei;
    e.edg = ee;
    sb.push_back(e);
    send_txn(tx, ty, set, gap, 1'b0);
    if (hold) begin
      in_valid = 1'b1;
      X = 10'd1023;
      Y = 10'd1023;
    end
    cyc = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while ((cyc < 40) && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (valid === 1'b1) got = 1'b1;
      else if (ready !== 1'b0) busy_ok = 1'b0;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, got ? cyc : 32'hFFFF_FFFF, LAT);
    chk({tag, " ready_low_busy"}, {31'd0, busy_ok}, 1);
    if (got) begin
      e = sb.pop_front();
      chk({tag, " is_inside"}, {31'd0, is_inside}, {31'd0, e.ins});
      chk({tag, " on_edge"}, {31'd0, on_edge}, {31'd0, e.edg});
      @(posedge clk); #1;
      chk({tag, " after_done v/r/in/edge"}, {28'd0, valid, ready, is_inside, on_edge},
          {28'd0, 1'b0, 1'b1, e.ins, e.edg});
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    int seen;
    reset    = 1'b0;
    in_valid = 1'b0;
    X        = '0;
    Y        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, ready}, 1);
    chk("reset valid", {31'd0, valid}, 0);
    chk("reset is_inside", {31'd0, is_inside}, 0);
    chk("reset on_edge", {31'd0, on_edge}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_txn("inside",      4,    5,    0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn("outside",     20,   20,   0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("on_edge",     8,    5,    0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_txn("on_vertex",   4,    0,    0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_txn("full_in",     512,  512,  1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn("full_out",    1023, 1023, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("left_edge",   0,    5,    0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_txn("gaps_hold",   4,    5,    0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Abort a transaction on its 5th SORT cycle; results must clear, no strobe
    send_txn(4, 5, 0, 1'b0, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("abort ready", {31'd0, ready}, 1);
    chk("abort valid", {31'd0, valid}, 0);
    chk("abort is_inside", {31'd0, is_inside}, 0);
    chk("abort on_edge", {31'd0, on_edge}, 0);
    reset = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (valid !== 1'b0) seen++;
    end
    chk("abort no_valid", seen, 0);
    chk("abort idle ready", {31'd0, ready}, 1);

    run_txn("post_abort",  4,    5,    0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
